ncl_sync_sink: RTL and testbench
================================

NCL_SYNC_SINK -- requirements
Module: ncl_sync_sink

Interface
REQ-001 SHALL have parameter WORD_W, default 8: number of dual-rail bits assembled per output word (2 to 32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flop depth of the input rail synchronizers (2 to 4).
REQ-003 SHALL have parameter CNT_W, default 16: width of the wavefront and error counters.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-005 SHALL have port init, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port a, input, 2 bits: dual-rail NCL channel from the last ring stage; 00 = NULL, 01 = DATA0, 10 = DATA1, 11 = illegal.
REQ-007 SHALL have port a_comp, output, 1 bit: completion to the upstream stage's ZCOMP; 0 = request DATA, 1 = request NULL.
REQ-008 SHALL have port word_out, output, WORD_W bits: assembled word.
REQ-009 SHALL have port word_valid, output, 1 bit: word_out holds an unread word.
REQ-010 SHALL have port word_ready, input, 1 bit: consumer accepts word_out when word_valid && word_ready.
REQ-011 SHALL have port wave_cnt, output, CNT_W bits: DATA wavefronts captured.
REQ-012 SHALL have port err_cnt, output, CNT_W bits: illegal-code occurrences.
REQ-013 SHALL have port err_flag, output, 1 bit: sticky illegal-code indicator.

Function
REQ-014 SHALL pass each rail of a through its own SYNC_STAGES-flop synchronizer; all decisions use only the synchronized value s.
REQ-015 SHALL implement FSM states S_REQD (a_comp=0, awaiting DATA) and S_REQN (a_comp=1, awaiting NULL); a_comp is a registered output.
REQ-016 In S_REQD, when s is 01 or 10 and capture is permitted, SHALL shift the bit (s[1]) into the assembly register, increment wave_cnt (wrapping), and move to S_REQN.
REQ-017 Capture SHALL be permitted unless the bit is the WORD_W-th of a word while word_valid=1 and word_ready=0; when capture is not permitted, the FSM SHALL hold S_REQD with a_comp=0, so the upstream stage holds its DATA.
REQ-018 Bits SHALL be placed LSB first: the first captured bit of a word becomes word_out[0].
REQ-019 On capture of the WORD_W-th bit, the assembled word SHALL load into word_out, word_valid SHALL be 1 from the next cycle, and the bit index SHALL return to 0.
REQ-020 word_valid SHALL clear on the cycle after word_valid && word_ready, unless a new word loads on that same edge, in which case it SHALL remain 1 with the new value.
REQ-021 In S_REQN, when s=00, the FSM SHALL move to S_REQD; a_comp SHALL fall on that edge.
REQ-022 On a transition of s into 11 from any other code, err_cnt SHALL increment, saturating at all-ones, and err_flag SHALL set; while s=11 no capture and no state change SHALL occur.
REQ-023 Latency: a_comp SHALL rise on the (SYNC_STAGES+1)th rising edge after the first edge that samples DATA on a, when capture is permitted.

Reset
REQ-024 While init=1 on an edge: synchronizers=00, state=S_REQD, a_comp=0, bit index=0, assembly register=0, word_out=0, word_valid=0, wave_cnt=0, err_cnt=0, err_flag=0.
REQ-025 Reset mid-word SHALL discard partial bits; DATA present on a after init falls SHALL be captured as bit 0 of a fresh word.

Verification
REQ-026 init high 2 cycles with a=10 -> during reset a_comp=0, word_valid=0, all counts 0; after release, a_comp=1 at edge SYNC_STAGES+1.
REQ-027 Eight 4-phase handshakes with bits 1,0,1,1,0,0,1,0 and word_ready=1 -> word_out=0x4D, word_valid=1 for one cycle, wave_cnt=8.
REQ-028 word_ready=0 and 16 bits sent -> first word is held, a_comp stays 0 on the 16th bit, and wave_cnt=15; a one-cycle word_ready pulse -> the second word loads, a_comp rises, word_valid stays 1, and wave_cnt=16.
REQ-029 a=11 for 3 cycles, then 00, then 11 again -> err_cnt=2, err_flag=1, wave_cnt unchanged, a_comp unchanged.
REQ-030 3 bits sent, init pulsed, then 8 bits 0xFF -> word_out=0xFF, word_valid=1, wave_cnt=8.
REQ-031 err_cnt preloaded near saturation via repeated 11 entries with CNT_W=4 -> err_cnt holds at 0xF after 16 or more entries.

Source files
------------

// File: rtl/ncl_sync_sink_if.sv
// Channel between the last NCL ring stage, the word consumer and the synchronous sink.
interface ncl_sync_sink_if #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 16
);
    logic [1:0]        a;
    logic              a_comp;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;
    logic [CNT_W-1:0]  wave_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic              err_flag;

    modport master (
        output a, word_ready,
        input  a_comp, word_out, word_valid, wave_cnt, err_cnt, err_flag
    );

    modport slave (
        input  a, word_ready,
        output a_comp, word_out, word_valid, wave_cnt, err_cnt, err_flag
    );
endinterface

// File: rtl/ncl_sync_sink.sv
// Synchronous sink for a dual-rail NCL ring: captures DATA wavefronts LSB first into words.
//   state  | meaning
//   S_REQD | a_comp=0, waiting for a DATA wavefront on the synchronized rails
//   S_REQN | a_comp=1, waiting for the NULL wavefront
module ncl_sync_sink #(
    parameter int WORD_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic           clk,
    input  logic           init,
    ncl_sync_sink_if.slave bus
);
    localparam int IDX_W = $clog2(WORD_W);

    typedef enum logic {
        S_REQD = 1'b0,
        S_REQN = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        sync_q [SYNC_STAGES];
    logic [1:0]        s_prev_q;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [WORD_W-1:0] asm_q, asm_d;
    logic [WORD_W-1:0] word_out_q, word_out_d;
    logic              word_valid_q, word_valid_d;
    logic [CNT_W-1:0]  wave_cnt_q, wave_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              err_flag_q, err_flag_d;

    logic [1:0] s;
    logic       s_is_data;
    logic       last_bit;
    logic       permit;

    assign s         = sync_q[SYNC_STAGES-1];
    assign s_is_data = (s == 2'b01) || (s == 2'b10);
    assign last_bit  = (bit_idx_q == IDX_W'(WORD_W - 1));
    // Refusing the final bit keeps a_comp low, so the ring itself holds the DATA.
    assign permit    = !(last_bit && word_valid_q && !bus.word_ready);

    always_ff @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 2'b00;
            s_prev_q     <= 2'b00;
            state_q      <= S_REQD;
            bit_idx_q    <= '0;
            asm_q        <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            wave_cnt_q   <= '0;
            err_cnt_q    <= '0;
            err_flag_q   <= 1'b0;
        end else begin
            sync_q[0] <= bus.a;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            s_prev_q     <= s;
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            asm_q        <= asm_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            wave_cnt_q   <= wave_cnt_d;
            err_cnt_q    <= err_cnt_d;
            err_flag_q   <= err_flag_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        asm_d        = asm_q;
        word_out_d   = word_out_q;
        word_valid_d = word_valid_q;
        wave_cnt_d   = wave_cnt_q;
        err_cnt_d    = err_cnt_q;
        err_flag_d   = err_flag_q;

        if (word_valid_q && bus.word_ready) word_valid_d = 1'b0;

        case (state_q)
            S_REQD: begin
                if (s_is_data && permit) begin
                    asm_d[bit_idx_q] = s[1];
                    wave_cnt_d       = wave_cnt_q + CNT_W'(1);
                    state_d          = S_REQN;
                    if (last_bit) begin
                        word_out_d   = asm_d;
                        word_valid_d = 1'b1;
                        bit_idx_d    = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            S_REQN: begin
                if (s == 2'b00) state_d = S_REQD;
            end
            default: state_d = S_REQD;
        endcase

        if (s == 2'b11 && s_prev_q != 2'b11) begin
            err_flag_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    assign bus.a_comp     = (state_q == S_REQN);
    assign bus.word_out   = word_out_q;
    assign bus.word_valid = word_valid_q;
    assign bus.wave_cnt   = wave_cnt_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.err_flag   = err_flag_q;
endmodule

// File: tb/tb_ncl_sync_sink.sv
// Directed bench for ncl_sync_sink: table of words plus hand-written stall, error and reset sequences.
module tb_ncl_sync_sink;
    logic clk = 1'b0;
    logic init;

    ncl_sync_sink_if #(.WORD_W(8), .CNT_W(16)) bus ();
    ncl_sync_sink_if #(.WORD_W(8), .CNT_W(4))  bus4 ();

    ncl_sync_sink #(.WORD_W(8), .SYNC_STAGES(2), .CNT_W(16)) dut (
        .clk (clk),
        .init(init),
        .bus (bus)
    );

    ncl_sync_sink #(.WORD_W(8), .SYNC_STAGES(2), .CNT_W(4)) dut4 (
        .clk (clk),
        .init(init),
        .bus (bus4)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // Free-running monitor counters; the test takes differences of snapshots.
    int         valid_cycles = 0;
    int         accept_cnt   = 0;
    logic [7:0] last_word    = 8'h00;

    always @(posedge clk) begin
        if (bus.word_valid) valid_cycles <= valid_cycles + 1;
        if (bus.word_valid && bus.word_ready) begin
            accept_cnt <= accept_cnt + 1;
            last_word  <= bus.word_out;
        end
    end

    typedef struct {
        logic [7:0]  word;
        logic [15:0] exp_wave;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_acomp(input logic val, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (bus.a_comp === val) ok = 1'b1;
        end
    endtask

    task automatic send_bit(input logic b);
        bit ok;
        bus.a = b ? 2'b10 : 2'b01;
        wait_acomp(1'b1, 20, ok);
        check("a_comp_rise_timeout", 32'(ok), 32'd1);
        bus.a = 2'b00;
        wait_acomp(1'b0, 20, ok);
        check("a_comp_fall_timeout", 32'(ok), 32'd1);
    endtask

    task automatic send_word(input logic [7:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(w[i]);
    endtask

    task automatic pulse_init();
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [4];
        int   vc0;
        int   ac0;
        bit   ok;

        vecs[0] = '{8'h4D, 16'd8};
        vecs[1] = '{8'h00, 16'd16};
        vecs[2] = '{8'hFF, 16'd24};
        vecs[3] = '{8'h81, 16'd32};

        init            = 1'b1;
        bus.a           = 2'b10;
        bus.word_ready  = 1'b1;
        bus4.a          = 2'b00;
        bus4.word_ready = 1'b1;

        // Reset held two edges with DATA present, then latency after release.
        repeat (2) @(negedge clk);
        check("rst_a_comp",     32'(bus.a_comp),     32'd0);
        check("rst_word_valid", 32'(bus.word_valid), 32'd0);
        check("rst_word_out",   32'(bus.word_out),   32'd0);
        check("rst_wave_cnt",   32'(bus.wave_cnt),   32'd0);
        check("rst_err_cnt",    32'(bus.err_cnt),    32'd0);
        check("rst_err_flag",   32'(bus.err_flag),   32'd0);
        init = 1'b0;
        repeat (2) @(negedge clk);
        check("lat_edge2_a_comp", 32'(bus.a_comp), 32'd0);
        @(negedge clk);
        check("lat_edge3_a_comp", 32'(bus.a_comp), 32'd1);
        bus.a = 2'b00;
        wait_acomp(1'b0, 20, ok);
        check("lat_null_timeout", 32'(ok), 32'd1);

        // Table-driven words with the consumer always ready.
        pulse_init();
        for (int v = 0; v < 4; v++) begin
            vc0 = valid_cycles;
            ac0 = accept_cnt;
            send_word(vecs[v].word, 8);
            repeat (2) @(negedge clk);
            check("tbl_word",         32'(last_word),           32'(vecs[v].word));
            check("tbl_accepts",      32'(accept_cnt - ac0),    32'd1);
            check("tbl_valid_cycles", 32'(valid_cycles - vc0),  32'd1);
            check("tbl_wave_cnt",     32'(bus.wave_cnt),        32'(vecs[v].exp_wave));
            check("tbl_valid_clear",  32'(bus.word_valid),      32'd0);
        end

        // Back-pressure: the 16th bit is refused until the consumer takes word 1.
        pulse_init();
        bus.word_ready = 1'b0;
        send_word(8'hA5, 8);
        send_word(8'h3C, 7);
        bus.a = 2'b01;
        repeat (10) @(negedge clk);
        check("stall_a_comp",     32'(bus.a_comp),     32'd0);
        check("stall_wave_cnt",   32'(bus.wave_cnt),   32'd15);
        check("stall_word_out",   32'(bus.word_out),   32'hA5);
        check("stall_word_valid", 32'(bus.word_valid), 32'd1);
        ac0 = accept_cnt;
        bus.word_ready = 1'b1;
        @(negedge clk);
        bus.word_ready = 1'b0;
        check("pulse_word_out",   32'(bus.word_out),     32'h3C);
        check("pulse_word_valid", 32'(bus.word_valid),   32'd1);
        check("pulse_a_comp",     32'(bus.a_comp),       32'd1);
        check("pulse_wave_cnt",   32'(bus.wave_cnt),     32'd16);
        check("pulse_accepted",   32'(last_word),        32'hA5);
        check("pulse_accept_cnt", 32'(accept_cnt - ac0), 32'd1);
        bus.a = 2'b00;
        wait_acomp(1'b0, 20, ok);
        check("pulse_null_timeout", 32'(ok), 32'd1);
        bus.word_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("drain_valid", 32'(bus.word_valid), 32'd0);

        // Illegal code: one count per entry into 11, no capture, no state change.
        bus.a = 2'b11;
        repeat (3) @(negedge clk);
        bus.a = 2'b00;
        repeat (3) @(negedge clk);
        check("err_first_cnt", 32'(bus.err_cnt), 32'd1);
        bus.a = 2'b11;
        repeat (3) @(negedge clk);
        bus.a = 2'b00;
        repeat (4) @(negedge clk);
        check("err_cnt",      32'(bus.err_cnt),  32'd2);
        check("err_flag",     32'(bus.err_flag), 32'd1);
        check("err_wave_cnt", 32'(bus.wave_cnt), 32'd16);
        check("err_a_comp",   32'(bus.a_comp),   32'd0);

        // Reset mid-word discards partial bits.
        pulse_init();
        check("reinit_err_flag", 32'(bus.err_flag), 32'd0);
        check("reinit_err_cnt",  32'(bus.err_cnt),  32'd0);
        send_word(8'h00, 3);
        pulse_init();
        bus.word_ready = 1'b0;
        send_word(8'hFF, 8);
        repeat (2) @(negedge clk);
        check("midrst_word_out",   32'(bus.word_out),   32'hFF);
        check("midrst_word_valid", 32'(bus.word_valid), 32'd1);
        check("midrst_wave_cnt",   32'(bus.wave_cnt),   32'd8);
        bus.word_ready = 1'b1;

        // Saturating error counter on the narrow-counter instance.
        for (int k = 1; k <= 20; k++) begin
            bus4.a = 2'b11;
            repeat (3) @(negedge clk);
            bus4.a = 2'b00;
            repeat (3) @(negedge clk);
            check("sat_err_cnt", 32'(bus4.err_cnt), (k > 15) ? 32'd15 : 32'(k));
        end
        check("sat_err_flag", 32'(bus4.err_flag), 32'd1);
        check("sat_wave_cnt", 32'(bus4.wave_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
